// File: rtl/blit_engine_pkg.sv
// Shared definitions for the rectangle fill/copy engine: state and op encodings
// plus default bus widths.
package blit_engine_pkg;

    localparam int BLIT_ADDR_W_DEF = 16;
    localparam int BLIT_DATA_W_DEF = 16;
    localparam int BLIT_DIM_W_DEF  = 12;

    localparam logic BLIT_OP_FILL = 1'b0;
    localparam logic BLIT_OP_COPY = 1'b1;

    typedef enum logic [2:0] {
        BLIT_IDLE    = 3'd0,
        BLIT_FILL_WR = 3'd1,
        BLIT_CP_RD   = 3'd2,
        BLIT_CP_WAIT = 3'd3,
        BLIT_CP_WR   = 3'd4,
        BLIT_DONE    = 3'd5
    } blit_state_t;

    function automatic logic is_empty_rect(input logic [BLIT_DIM_W_DEF-1:0] w,
                                           input logic [BLIT_DIM_W_DEF-1:0] h);
        return (w == '0) || (h == '0);
    endfunction

endpackage

// File: rtl/blit_engine_if.sv
// Command handshake and VRAM slot bus of the blit engine; names are seen from the engine.
interface blit_engine_if #(
    parameter int ADDR_W = blit_engine_pkg::BLIT_ADDR_W_DEF,
    parameter int DATA_W = blit_engine_pkg::BLIT_DATA_W_DEF,
    parameter int DIM_W  = blit_engine_pkg::BLIT_DIM_W_DEF
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_copy_i;
    logic [ADDR_W-1:0] cmd_src_i;
    logic [ADDR_W-1:0] cmd_dst_i;
    logic [DIM_W-1:0]  cmd_width_i;
    logic [DIM_W-1:0]  cmd_height_i;
    logic [DIM_W-1:0]  cmd_src_stride_i;
    logic [DIM_W-1:0]  cmd_dst_stride_i;
    logic [DATA_W-1:0] cmd_fill_i;
    logic              blit_cycle_i;
    logic              blit_sel_o;
    logic              blit_wr_o;
    logic [ADDR_W-1:0] blit_addr_o;
    logic [DATA_W-1:0] blit_data_i;
    logic [DATA_W-1:0] blit_data_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  cmd_valid_i, cmd_copy_i, cmd_src_i, cmd_dst_i, cmd_width_i, cmd_height_i,
               cmd_src_stride_i, cmd_dst_stride_i, cmd_fill_i, blit_cycle_i, blit_data_i,
        output cmd_ready_o, blit_sel_o, blit_wr_o, blit_addr_o, blit_data_o, busy_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_copy_i, cmd_src_i, cmd_dst_i, cmd_width_i, cmd_height_i,
               cmd_src_stride_i, cmd_dst_stride_i, cmd_fill_i, blit_cycle_i, blit_data_i,
        input  cmd_ready_o, blit_sel_o, blit_wr_o, blit_addr_o, blit_data_o, busy_o, done_o
    );
endinterface

// File: rtl/blit_engine_addr_gen.sv
// Row-major rectangle walker: row-start pointer plus column/row counters, all
// address arithmetic wrapping modulo 2^ADDR_W.
module blit_addr_gen
    import blit_engine_pkg::*;
#(
    parameter int ADDR_W = BLIT_ADDR_W_DEF,
    parameter int DIM_W  = BLIT_DIM_W_DEF
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [DIM_W-1:0]  width_i,
    input  logic [DIM_W-1:0]  height_i,
    input  logic [DIM_W-1:0]  stride_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_col_o,
    output logic              last_word_o
);
    logic [ADDR_W-1:0] row_q;
    logic [DIM_W-1:0]  col_q, rows_q, width_q, height_q, stride_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            row_q    <= '0;
            col_q    <= '0;
            rows_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            stride_q <= '0;
        end else if (load_i) begin
            row_q    <= base_i;
            col_q    <= '0;
            rows_q   <= '0;
            width_q  <= width_i;
            height_q <= height_i;
            stride_q <= stride_i;
        end else if (step_i) begin
            if (last_col_o) begin
                col_q  <= '0;
                rows_q <= rows_q + DIM_W'(1);
                row_q  <= row_q + ADDR_W'(stride_q);
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end

    assign last_col_o  = (col_q == width_q - DIM_W'(1));
    assign last_word_o = last_col_o && (rows_q == height_q - DIM_W'(1));
    assign addr_o      = row_q + ADDR_W'(col_q);
endmodule

// File: rtl/blit_engine.sv
// Rectangle fill/copy engine issuing VRAM accesses only in granted slots.
// IDLE: wait for command | FILL_WR: write fill word per slot | CP_RD: issue source read
// CP_WAIT: wait RD_LAT for read data | CP_WR: write captured word | DONE: pulse done_o
module blit_engine
    import blit_engine_pkg::*;
#(
    parameter int ADDR_W = BLIT_ADDR_W_DEF,
    parameter int DATA_W = BLIT_DATA_W_DEF,
    parameter int DIM_W  = BLIT_DIM_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         reset_i,
    blit_engine_if.slave bus
);
    blit_state_t       state_q;
    logic              ready_q, busy_q, done_q, sel_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, fill_q, cap_q;
    logic [RD_LAT:1]   rd_sh_q;

    logic              accept, zero_size, src_step, dst_step, rd_strobe;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic              src_last_col, src_last_word, dst_last_col, dst_last_word;
    logic              gen_unused;

    assign accept    = (state_q == BLIT_IDLE) && ready_q && bus.cmd_valid_i;
    assign zero_size = (bus.cmd_width_i == '0) || (bus.cmd_height_i == '0);
    assign src_step  = (state_q == BLIT_CP_RD) && bus.blit_cycle_i;
    assign dst_step  = ((state_q == BLIT_FILL_WR) || (state_q == BLIT_CP_WR)) && bus.blit_cycle_i;
    assign rd_strobe = sel_q && !wr_q;
    assign gen_unused = src_last_col & src_last_word & dst_last_col;

    blit_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_src (
        .clk(clk), .reset_i(reset_i), .load_i(accept), .step_i(src_step),
        .base_i(bus.cmd_src_i), .width_i(bus.cmd_width_i), .height_i(bus.cmd_height_i),
        .stride_i(bus.cmd_src_stride_i), .addr_o(src_addr),
        .last_col_o(src_last_col), .last_word_o(src_last_word)
    );

    // Completion is decided by the destination walker alone.
    blit_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_dst (
        .clk(clk), .reset_i(reset_i), .load_i(accept), .step_i(dst_step),
        .base_i(bus.cmd_dst_i), .width_i(bus.cmd_width_i), .height_i(bus.cmd_height_i),
        .stride_i(bus.cmd_dst_stride_i), .addr_o(dst_addr),
        .last_col_o(dst_last_col), .last_word_o(dst_last_word)
    );

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rd_sh_q <= '0;
        end else begin
            rd_sh_q[1] <= rd_strobe;
            for (int i = 2; i <= RD_LAT; i++) rd_sh_q[i] <= rd_sh_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= BLIT_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            fill_q  <= '0;
            cap_q   <= '0;
        end else begin
            sel_q  <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                BLIT_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        fill_q  <= bus.cmd_fill_i;
                        if (zero_size)                         state_q <= BLIT_DONE;
                        else if (bus.cmd_copy_i == BLIT_OP_COPY) state_q <= BLIT_CP_RD;
                        else                                   state_q <= BLIT_FILL_WR;
                    end
                end
                BLIT_FILL_WR: if (bus.blit_cycle_i) begin
                    sel_q  <= 1'b1;
                    wr_q   <= 1'b1;
                    addr_q <= dst_addr;
                    data_q <= fill_q;
                    if (dst_last_word) state_q <= BLIT_DONE;
                end
                BLIT_CP_RD: if (bus.blit_cycle_i) begin
                    sel_q   <= 1'b1;
                    addr_q  <= src_addr;
                    state_q <= BLIT_CP_WAIT;
                end
                BLIT_CP_WAIT: if (rd_sh_q[RD_LAT]) begin
                    cap_q   <= bus.blit_data_i;
                    state_q <= BLIT_CP_WR;
                end
                BLIT_CP_WR: if (bus.blit_cycle_i) begin
                    sel_q   <= 1'b1;
                    wr_q    <= 1'b1;
                    addr_q  <= dst_addr;
                    data_q  <= cap_q;
                    state_q <= dst_last_word ? BLIT_DONE : BLIT_CP_RD;
                end
                BLIT_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= BLIT_IDLE;
                end
                default: state_q <= BLIT_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o = ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.blit_sel_o  = sel_q;
    assign bus.blit_wr_o   = wr_q;
    assign bus.blit_addr_o = addr_q;
    assign bus.blit_data_o = data_q;
endmodule

// File: tb/tb_blit_engine.sv
// Directed bench for blit_engine: table of rectangle commands checked against a
// row-major address model, plus zero-size and mid-command reset sequences.
module tb_blit_engine;
    localparam int RD_LAT = 2;
    localparam int LOG_N  = 512;

    typedef struct {
        logic        copy;
        logic [15:0] src;
        logic [15:0] dst;
        logic [11:0] w;
        logic [11:0] h;
        logic [11:0] ss;
        logic [11:0] ds;
        logic [15:0] fill;
        int          period;
        int          exp_n;
        logic [15:0] exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic reset_i;
    int   n_tests = 0;
    int   n_fail  = 0;

    int          cyc = 0;
    int          blit_period = 1;
    int          n_acc = 0;
    int          n_done = 0;
    int          done_cyc = 0;
    logic        done_busy = 1'b0;
    logic [15:0] log_addr [LOG_N];
    logic [15:0] log_data [LOG_N];
    logic        log_wr   [LOG_N];
    int          log_cyc  [LOG_N];
    logic [15:0] pipe [1:RD_LAT+1] = '{default: 16'hDEAD};

    vec_t vecs [5];

    blit_engine_if #(.ADDR_W(16), .DATA_W(16), .DIM_W(12)) bus ();

    blit_engine #(.ADDR_W(16), .DATA_W(16), .DIM_W(12), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_i(reset_i), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] vram_f(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    assign bus.blit_data_i = pipe[RD_LAT+1];

    // Monitor, read-latency VRAM model and slot generator, all on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.blit_sel_o) begin
            if (n_acc < LOG_N) begin
                log_addr[n_acc] = bus.blit_addr_o;
                log_data[n_acc] = bus.blit_data_o;
                log_wr[n_acc]   = bus.blit_wr_o;
                log_cyc[n_acc]  = cyc;
            end
            n_acc = n_acc + 1;
        end
        if (bus.done_o) begin
            n_done    = n_done + 1;
            done_cyc  = cyc;
            done_busy = bus.busy_o;
        end
        for (int i = RD_LAT + 1; i > 1; i--) pipe[i] = pipe[i-1];
        pipe[1] = (bus.blit_sel_o && !bus.blit_wr_o) ? vram_f(bus.blit_addr_o) : 16'hDEAD;
        bus.blit_cycle_i = (blit_period <= 1) || ((cyc % blit_period) == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_copy_i       = v.copy;
        bus.cmd_src_i        = v.src;
        bus.cmd_dst_i        = v.dst;
        bus.cmd_width_i      = v.w;
        bus.cmd_height_i     = v.h;
        bus.cmd_src_stride_i = v.ss;
        bus.cmd_dst_stride_i = v.ds;
        bus.cmd_fill_i       = v.fill;
    endtask

    task automatic scramble_cmd();
        bus.cmd_copy_i       = ~bus.cmd_copy_i;
        bus.cmd_src_i        = 16'h7777;
        bus.cmd_dst_i        = 16'hDEAD;
        bus.cmd_width_i      = 12'd9;
        bus.cmd_height_i     = 12'd9;
        bus.cmd_src_stride_i = 12'h333;
        bus.cmd_dst_stride_i = 12'h444;
        bus.cmd_fill_i       = 16'h0BAD;
    endtask

    task automatic issue(input vec_t v, output int c0);
        int k = 0;
        @(posedge clk); #1;
        while (!bus.cmd_ready_o && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait_timeout", (k >= 100), 0);
        drive_cmd(v);
        bus.cmd_valid_i = 1'b1;
        c0 = cyc + 1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        scramble_cmd();
        chk("busy_after_accept", bus.busy_o, 1);
        chk("ready_after_accept", bus.cmd_ready_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          s0, d0, c0, k, last;
        logic [15:0] e_addr[$];
        logic [15:0] e_data[$];
        logic        e_wr[$];
        logic [15:0] sa, da;
        s0 = n_acc;
        d0 = n_done;
        blit_period = v.period;
        issue(v, c0);
        k = 0;
        while (n_done == d0 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, " done_timeout"}, (k >= 2000), 0);
        chk({tag, " ready_after_done"}, bus.cmd_ready_o, 1);
        chk({tag, " busy_at_done"}, done_busy, 0);
        repeat (4) @(posedge clk);
        #1;
        for (int r = 0; r < int'(v.h); r++) begin
            for (int c = 0; c < int'(v.w); c++) begin
                sa = 16'(int'(v.src) + r * int'(v.ss) + c);
                da = 16'(int'(v.dst) + r * int'(v.ds) + c);
                if (v.copy) begin
                    e_addr.push_back(sa); e_wr.push_back(1'b0); e_data.push_back(16'h0);
                    e_addr.push_back(da); e_wr.push_back(1'b1); e_data.push_back(vram_f(sa));
                end else begin
                    e_addr.push_back(da); e_wr.push_back(1'b1); e_data.push_back(v.fill);
                end
            end
        end
        chk({tag, " strobe_count"}, n_acc - s0, v.exp_n);
        chk({tag, " done_count"}, n_done - d0, 1);
        for (int i = 0; i < e_addr.size() && (s0 + i) < n_acc && (s0 + i) < LOG_N; i++) begin
            chk($sformatf("%s wr[%0d]", tag, i), log_wr[s0+i], e_wr[i]);
            chk($sformatf("%s addr[%0d]", tag, i), log_addr[s0+i], e_addr[i]);
            if (e_wr[i]) chk($sformatf("%s data[%0d]", tag, i), log_data[s0+i], e_data[i]);
        end
        if (n_acc > s0 && n_acc <= LOG_N) begin
            last = n_acc - 1;
            chk({tag, " last_addr"}, log_addr[last], v.exp_last);
            chk({tag, " done_after_last_wr"}, done_cyc, log_cyc[last] + 1);
            chk({tag, " first_strobe_latency"}, (log_cyc[s0] >= c0 + 2), 1);
        end
    endtask

    initial begin
        vec_t zv, rv;
        int   s0, d0, c0, k;

        vecs[0] = '{1'b0, 16'h0000, 16'h0100, 12'd4, 12'd3, 12'h000, 12'h050, 16'h1F20, 1, 12, 16'h01A3};
        vecs[1] = '{1'b1, 16'h0000, 16'h2000, 12'd3, 12'd2, 12'h010, 12'h020, 16'h0000, 3, 12, 16'h2022};
        vecs[2] = '{1'b0, 16'h0000, 16'hFFFE, 12'd4, 12'd1, 12'h000, 12'h000, 16'hBEEF, 1, 4,  16'h0001};
        vecs[3] = '{1'b0, 16'h0000, 16'h0300, 12'd3, 12'd2, 12'h000, 12'h001, 16'h1234, 2, 6,  16'h0303};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h4000, 12'd2, 12'd2, 12'h100, 12'h003, 16'h0000, 1, 8,  16'h4004};

        reset_i = 1'b1;
        drive_cmd(vecs[2]);
        bus.cmd_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst sel", bus.blit_sel_o, 0);
        chk("rst wr", bus.blit_wr_o, 0);
        chk("rst busy", bus.busy_o, 0);
        chk("rst done", bus.done_o, 0);
        chk("rst ready", bus.cmd_ready_o, 0);
        chk("rst addr", bus.blit_addr_o, 0);
        chk("rst data", bus.blit_data_o, 0);
        reset_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("post_rst ready", bus.cmd_ready_o, 1);
        chk("post_rst busy", bus.busy_o, 0);
        chk("post_rst strobes", n_acc, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Zero-size command; a second command is held valid while busy.
        zv = '{1'b0, 16'h0000, 16'h0600, 12'd0, 12'd5, 12'h000, 12'h010, 16'h5555, 1, 0, 16'h0000};
        s0 = n_acc;
        d0 = n_done;
        issue(zv, c0);
        drive_cmd('{1'b0, 16'h0000, 16'h0777, 12'd1, 12'd1, 12'h000, 12'h000, 16'h9999, 1, 1, 16'h0777});
        bus.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        chk("zero ready_during_busy", bus.cmd_ready_o, 0);
        chk("zero done_pulse", bus.done_o, 1);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        chk("zero ready_back", bus.cmd_ready_o, 1);
        chk("zero busy_low", bus.busy_o, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("zero strobes", n_acc - s0, 0);
        chk("zero done_count", n_done - d0, 1);
        chk("zero done_cycle", done_cyc, c0 + 2);

        // Reset after the 5th write of a 12-word fill.
        rv = '{1'b0, 16'h0000, 16'h0500, 12'd4, 12'd3, 12'h000, 12'h010, 16'hAAAA, 1, 12, 16'h0523};
        blit_period = 1;
        s0 = n_acc;
        d0 = n_done;
        issue(rv, c0);
        k = 0;
        while ((n_acc - s0) < 5 && k < 200) begin
            @(posedge clk); #6;
            k++;
        end
        chk("midrst wait_timeout", (k >= 200), 0);
        @(posedge clk);
        reset_i = 1'b1;
        #1;
        chk("midrst sel", bus.blit_sel_o, 0);
        chk("midrst busy", bus.busy_o, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst strobes", n_acc - s0, 5);
        chk("midrst no_done", n_done - d0, 0);
        chk("midrst ready", bus.cmd_ready_o, 1);

        run_vec(vecs[0], "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
